// File: rtl/mnist_infer_ctrl.sv
// rtl/mnist_infer_ctrl.sv - inference sequencer with signed argmax over engine class scores
// Optional watchdog: define INFER_TIMEOUT_EN to add the WAIT-state timeout and ERR state.
module mnist_infer_ctrl #(
  parameter int DATA_WIDTH     = 3,
  parameter int NUM_CLASSES    = 10,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  output logic                         eng_reset,
  output logic                         eng_start,
  input  logic                         eng_done,
  output logic [3:0]                   eng_out_idx,
  input  logic signed [DATA_WIDTH-1:0] eng_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [3:0]                   res_class,
  output logic signed [DATA_WIDTH-1:0] res_score,
  output logic                         res_tie,
  output logic                         busy,
  output logic                         err_timeout
);

`ifdef INFER_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_START, S_WAIT, S_SCAN, S_RESULT, S_ERR
  } state_e;
  localparam logic [20:0] TO_LAST = 21'(TIMEOUT_CYCLES - 1);
  logic [20:0] wait_cnt_q;
  logic        err_timeout_q;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_START, S_WAIT, S_SCAN, S_RESULT
  } state_e;
`endif

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  state_e                       state_q;
  logic                         req_ready_q;
  logic                         eng_reset_q;
  logic                         eng_start_q;
  logic [3:0]                   idx_q;
  logic                         res_valid_q;
  logic [3:0]                   res_class_q;
  logic signed [DATA_WIDTH-1:0] res_score_q;
  logic                         res_tie_q;
  logic                         busy_q;
  logic signed [DATA_WIDTH-1:0] best_score_q, best_score_d;
  logic [3:0]                   best_idx_q, best_idx_d;
  logic                         tie_q, tie_d;

  // Running argmax: fold the currently selected score into the best-so-far
  always_comb begin
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    tie_d        = tie_q;
    if (idx_q == 4'd0) begin
      best_score_d = eng_out;
      best_idx_d   = idx_q;
      tie_d        = 1'b0;
    end else if (eng_out > best_score_q) begin
      best_score_d = eng_out;
      best_idx_d   = idx_q;
      tie_d        = 1'b0;
    end else if (eng_out == best_score_q) begin
      tie_d        = 1'b1;
    end
  end

  // Sequencer FSM; every output is a register updated on the state transition
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      eng_reset_q  <= 1'b0;
      eng_start_q  <= 1'b0;
      idx_q        <= 4'd0;
      res_valid_q  <= 1'b0;
      res_class_q  <= 4'd0;
      res_score_q  <= '0;
      res_tie_q    <= 1'b0;
      busy_q       <= 1'b0;
      best_score_q <= '0;
      best_idx_q   <= 4'd0;
      tie_q        <= 1'b0;
`ifdef INFER_TIMEOUT_EN
      wait_cnt_q    <= 21'd0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      eng_reset_q <= 1'b0;
      eng_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            state_q     <= S_CLEAR;
            eng_reset_q <= 1'b1;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_CLEAR: begin
          state_q     <= S_START;
          eng_start_q <= 1'b1;
        end
        S_START: begin
          state_q <= S_WAIT;
`ifdef INFER_TIMEOUT_EN
          wait_cnt_q <= 21'd0;
`endif
        end
        S_WAIT: begin
          if (eng_done) begin
            state_q <= S_SCAN;
            idx_q   <= 4'd0;
`ifdef INFER_TIMEOUT_EN
          end else if (wait_cnt_q == TO_LAST) begin
            state_q       <= S_ERR;
            res_valid_q   <= 1'b1;
            res_class_q   <= 4'hF;
            res_score_q   <= '0;
            res_tie_q     <= 1'b0;
            err_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 21'd1;
`endif
          end
        end
        S_SCAN: begin
          best_score_q <= best_score_d;
          best_idx_q   <= best_idx_d;
          tie_q        <= tie_d;
          if (idx_q == LAST_IDX) begin
            state_q     <= S_RESULT;
            idx_q       <= 4'd0;
            res_valid_q <= 1'b1;
            res_class_q <= best_idx_d;
            res_score_q <= best_score_d;
            res_tie_q   <= tie_d;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
`ifdef INFER_TIMEOUT_EN
        S_ERR: begin
          if (res_ready) begin
            state_q       <= S_IDLE;
            res_valid_q   <= 1'b0;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
          end
        end
`endif
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
          idx_q       <= 4'd0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign eng_reset   = eng_reset_q;
  assign eng_start   = eng_start_q;
  assign eng_out_idx = idx_q;
  assign res_valid   = res_valid_q;
  assign res_class   = res_class_q;
  assign res_score   = res_score_q;
  assign res_tie     = res_tie_q;
  assign busy        = busy_q;
`ifdef INFER_TIMEOUT_EN
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mnist_infer_ctrl.sv
// tb/tb_mnist_infer_ctrl.sv - directed self-checking bench for mnist_infer_ctrl
module tb_mnist_infer_ctrl;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              eng_done = 1'b0;
  logic              res_ready = 1'b0;
  logic              req_ready, eng_reset, eng_start, res_valid, res_tie, busy, err_timeout;
  logic [3:0]        eng_out_idx, res_class;
  logic signed [2:0] eng_out, res_score;
  logic signed [2:0] scores [10];

  int n_checks = 0;
  int n_fail   = 0;

  mnist_infer_ctrl #(
    .DATA_WIDTH(3),
    .NUM_CLASSES(10),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .eng_reset(eng_reset), .eng_start(eng_start), .eng_done(eng_done),
    .eng_out_idx(eng_out_idx), .eng_out(eng_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_score(res_score), .res_tie(res_tie),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Engine output mux model
  always_comb begin
    eng_out = 3'sd0;
    if (eng_out_idx < 4'd10) eng_out = scores[int'(eng_out_idx)];
  end

  task automatic load_scores(input int v0, v1, v2, v3, v4, v5, v6, v7, v8, v9);
    scores[0] = 3'(v0); scores[1] = 3'(v1); scores[2] = 3'(v2); scores[3] = 3'(v3);
    scores[4] = 3'(v4); scores[5] = 3'(v5); scores[6] = 3'(v6); scores[7] = 3'(v7);
    scores[8] = 3'(v8); scores[9] = 3'(v9);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first WAIT cycle
  task automatic go_to_wait();
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Called at the negedge where eng_done was raised; counts cycles until res_valid
  task automatic wait_result(output int lat, output int idx_bad);
    lat = 0;
    idx_bad = 0;
    do begin
      @(negedge clk);
      eng_done = 1'b0;
      lat++;
      if (lat <= 10 && eng_out_idx !== 4'(lat - 1)) idx_bad++;
    end while (!res_valid && lat < 60);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat, bad;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({req_ready, busy, res_valid, eng_reset, eng_start, res_tie, err_timeout} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 1000000",
               {req_ready, busy, res_valid, eng_reset, eng_start, res_tie, err_timeout});
    end
    n_checks++;
    if (eng_out_idx !== 4'd0 || res_class !== 4'd0 || res_score !== 3'sd0) begin
      n_fail++;
      $display("FAIL reset_fields got idx=%0d class=%0d score=%0d want 0/0/0",
               eng_out_idx, res_class, res_score);
    end
    rst = 1'b1;
    @(negedge clk);
    load_scores(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    go_to_wait();
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (eng_out_idx !== 4'd3 || !busy) begin
      n_fail++;
      $display("FAIL mid_scan_idx got idx=%0d busy=%b want 3/1", eng_out_idx, busy);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, busy, res_valid} !== 3'b100 || eng_out_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_scan_reset got rdy/busy/vld=%b idx=%0d want 100/0",
               {req_ready, busy, res_valid}, eng_out_idx);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle got rdy=%b busy=%b want 1/0", req_ready, busy);
    end
    lat = 0; bad = 0;
  endtask

  task automatic test_single();
    int lat, bad;
    load_scores(-1, 2, 0, 3, 1, -4, 0, 2, -2, 1);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if ({eng_reset, eng_start, busy, req_ready} !== 4'b1010) begin
      n_fail++;
      $display("FAIL clear_cycle got rst/start/busy/rdy=%b want 1010",
               {eng_reset, eng_start, busy, req_ready});
    end
    @(negedge clk);
    n_checks++;
    if ({eng_reset, eng_start} !== 2'b01) begin
      n_fail++;
      $display("FAIL start_cycle got rst/start=%b want 01", {eng_reset, eng_start});
    end
    @(negedge clk);
    n_checks++;
    if ({eng_reset, eng_start, res_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL wait_cycle got rst/start/vld=%b want 000", {eng_reset, eng_start, res_valid});
    end
    repeat (4) @(negedge clk);
    eng_done = 1'b1;
    wait_result(lat, bad);
    n_checks++;
    if (lat !== 11) begin
      n_fail++;
      $display("FAIL single_latency got %0d want 11", lat);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL scan_idx_sequence got %0d wrong cycles want 0", bad);
    end
    n_checks++;
    if (res_class !== 4'd3 || res_score !== 3'sd3 || res_tie !== 1'b0 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result got class=%0d score=%0d tie=%b err=%b want 3/3/0/0",
               res_class, res_score, res_tie, err_timeout);
    end
    handshake();
    n_checks++;
    if ({res_valid, req_ready, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL single_release got vld/rdy/busy=%b want 010", {res_valid, req_ready, busy});
    end
  endtask

  task automatic test_ties();
    int lat, bad;
    logic signed [2:0] exp_s;
    load_scores(-2, -2, -2, -2, -2, -2, -2, -2, -2, -2);
    exp_s = -3'sd2;
    go_to_wait();
    eng_done = 1'b1;
    wait_result(lat, bad);
    n_checks++;
    if (res_class !== 4'd0 || res_score !== exp_s || res_tie !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_all_neg got class=%0d score=%0d tie=%b want 0/-2/1", res_class, res_score, res_tie);
    end
    handshake();
    @(negedge clk);
    load_scores(0, 1, 3, -1, 2, 0, 1, 3, -4, 2);
    go_to_wait();
    eng_done = 1'b1;
    wait_result(lat, bad);
    n_checks++;
    if (res_class !== 4'd2 || res_score !== 3'sd3 || res_tie !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_max_2_7 got class=%0d score=%0d tie=%b want 2/3/1", res_class, res_score, res_tie);
    end
    handshake();
    @(negedge clk);
    load_scores(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    go_to_wait();
    eng_done = 1'b1;
    wait_result(lat, bad);
    n_checks++;
    if (res_class !== 4'd2 || res_score !== 3'sd3 || res_tie !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_cleared got class=%0d score=%0d tie=%b want 2/3/0", res_class, res_score, res_tie);
    end
    handshake();
    @(negedge clk);
    load_scores(-3, -4, -4, -4, -4, -4, -4, -4, -4, -1);
    go_to_wait();
    eng_done = 1'b1;
    wait_result(lat, bad);
    exp_s = -3'sd1;
    n_checks++;
    if (res_class !== 4'd9 || res_score !== exp_s || res_tie !== 1'b0) begin
      n_fail++;
      $display("FAIL last_class_wins got class=%0d score=%0d tie=%b want 9/-1/0", res_class, res_score, res_tie);
    end
    handshake();
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat, bad, unstable;
    load_scores(0, -3, 1, 1, -1, 2, -2, 2, 0, -4);
    go_to_wait();
    eng_done = 1'b1;
    wait_result(lat, bad);
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      req_valid = (i % 3 == 0);
      eng_done = i[0];
      @(negedge clk);
      if (!res_valid || res_class !== 4'd5 || res_score !== 3'sd2 || res_tie !== 1'b1 ||
          req_ready || !busy) unstable++;
    end
    req_valid = 1'b0;
    eng_done = 1'b0;
    n_checks++;
    if (unstable !== 0) begin
      n_fail++;
      $display("FAIL backpressure_hold got %0d unstable cycles want 0", unstable);
    end
    handshake();
    n_checks++;
    if ({res_valid, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL backpressure_release got vld/rdy=%b want 01", {res_valid, req_ready});
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_idle got busy=%b want 0", busy);
    end
  endtask

`ifdef INFER_TIMEOUT_EN
  task automatic test_watchdog();
    int lat, bad, n;
    load_scores(0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    go_to_wait();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 200);
    n_checks++;
    if (n !== 64) begin
      n_fail++;
      $display("FAIL timeout_latency got %0d want 64", n);
    end
    n_checks++;
    if (res_class !== 4'hF || res_score !== 3'sd0 || res_tie !== 1'b0 || err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_result got class=%0d score=%0d tie=%b err=%b want 15/0/0/1",
               res_class, res_score, res_tie, err_timeout);
    end
    handshake();
    n_checks++;
    if (err_timeout !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_release got err=%b vld=%b rdy=%b want 0/0/1", err_timeout, res_valid, req_ready);
    end
    go_to_wait();
    repeat (63) @(negedge clk);
    eng_done = 1'b1;
    wait_result(lat, bad);
    n_checks++;
    if (lat !== 11 || res_class !== 4'd4 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL done_at_limit got lat=%0d class=%0d err=%b want 11/4/0", lat, res_class, err_timeout);
    end
    handshake();
    @(negedge clk);
  endtask
`else
  task automatic test_no_watchdog();
    int lat, bad;
    load_scores(0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    go_to_wait();
    repeat (200) @(negedge clk);
    n_checks++;
    if ({res_valid, busy, err_timeout} !== 3'b010) begin
      n_fail++;
      $display("FAIL wait_holds got vld/busy/err=%b want 010", {res_valid, busy, err_timeout});
    end
    eng_done = 1'b1;
    wait_result(lat, bad);
    n_checks++;
    if (lat !== 11 || res_class !== 4'd4 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL late_done got lat=%0d class=%0d err=%b want 11/4/0", lat, res_class, err_timeout);
    end
    handshake();
    @(negedge clk);
  endtask
`endif

  task automatic test_back_to_back();
    int rst_cyc [$];
    logic rv [41];
    load_scores(1, 0, -1, 2, 0, 0, 0, 0, 0, 0);
    req_valid = 1'b1;
    res_ready = 1'b1;
    eng_done  = 1'b1;
    rv[0] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      rv[c] = res_valid;
      if (eng_reset) rst_cyc.push_back(c);
    end
    req_valid = 1'b0;
    n_checks++;
    if (rst_cyc.size() < 2) begin
      n_fail++;
      $display("FAIL b2b_clear_count got %0d want >=2", rst_cyc.size());
    end else begin
      n_checks++;
      if (rst_cyc[0] !== 1 || rst_cyc[1] !== 16) begin
        n_fail++;
        $display("FAIL b2b_clear_cycles got %0d,%0d want 1,16", rst_cyc[0], rst_cyc[1]);
      end
    end
    n_checks++;
    if ({rv[13], rv[14], rv[15]} !== 3'b010) begin
      n_fail++;
      $display("FAIL b2b_result_pulse got %b want 010", {rv[13], rv[14], rv[15]});
    end
    n_checks++;
    if (res_class !== 4'd3 || res_score !== 3'sd2) begin
      n_fail++;
      $display("FAIL b2b_result got class=%0d score=%0d want 3/2", res_class, res_score);
    end
    repeat (30) @(negedge clk);
    res_ready = 1'b0;
    eng_done = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain got rdy=%b busy=%b want 1/0", req_ready, busy);
    end
  endtask

  initial begin
    load_scores(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_ties();
    test_backpressure();
`ifdef INFER_TIMEOUT_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
